// File: rtl/sr_pkg.sv
// ---------------------------------------------------------------------------
// sr_pkg : shared state encoding and default width for the shift-register link
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sr_pkg;

  localparam int   SR_WIDTH = 4;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  typedef enum logic {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT
  } sr_state_e;

endpackage : sr_pkg

`default_nettype wire

// File: rtl/sr_bit_counter.sv
// ---------------------------------------------------------------------------
// sr_bit_counter : 0..WIDTH-1 bit-position counter, saturating at terminal count
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sr_bit_counter
  import sr_pkg::*;
#(
  parameter int WIDTH = SR_WIDTH,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          clear,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          tc
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  assign tc = (count == LAST);

  // Clear wins over enable so a new word always restarts at bit 0.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + CW'(1);
    end
  end

endmodule : sr_bit_counter

`default_nettype wire

// File: rtl/piso_tx.sv
// ---------------------------------------------------------------------------
// piso_tx : parallel-in/serial-out transmitter with ready/load handshake
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module piso_tx
  import sr_pkg::*;
#(
  parameter int WIDTH     = SR_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] pi,
  input  logic             load,
  output logic             ready,
  output logic             so,
  output logic             so_valid,
  output logic             done
);

  localparam int            CW     = $clog2(WIDTH);
  localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

  generate
    if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
      $error("piso_tx: WIDTH must be in 2..32");
    end
  endgenerate

  sr_state_e        state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shifted;
  logic [CW-1:0]    cnt;
  logic             tc;
  logic             accept;
  logic             advance;
  logic             clear;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  assign ready   = (state == S_IDLE) || (state == S_SHIFT && tc);
  assign accept  = load && ready;
  assign advance = (state == S_SHIFT) && !tc;
  assign clear   = accept || (state == S_SHIFT && tc);

  // The bit currently on so sits at the output end of shreg.
  always_comb begin
    shifted = shreg;
    if (MSB_FIRST) begin
      shifted = {shreg[WIDTH-2:0], 1'b0};
    end else begin
      shifted = {1'b0, shreg[WIDTH-1:1]};
    end
  end

  sr_bit_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_bit_counter (
    .clk   (clk),
    .clr_n (clr_n),
    .clear (clear),
    .en    (advance),
    .count (cnt),
    .tc    (tc)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= S_IDLE;
      shreg    <= '0;
      so       <= 1'b0;
      so_valid <= 1'b0;
      done     <= 1'b0;
    end else if (accept) begin
      state    <= S_SHIFT;
      shreg    <= pi;
      so       <= first_bit(pi);
      so_valid <= 1'b1;
      done     <= 1'b0;
    end else if (advance) begin
      shreg    <= shifted;
      so       <= first_bit(shifted);
      done     <= (cnt == PENULT);
    end else if (state == S_SHIFT) begin
      state    <= S_IDLE;
      shreg    <= '0;
      so       <= 1'b0;
      so_valid <= 1'b0;
      done     <= 1'b0;
    end
  end

endmodule : piso_tx

`default_nettype wire

// File: tb/tb_piso_tx.sv
// ---------------------------------------------------------------------------
// tb_piso_tx : scoreboard bench for piso_tx, MSB-first and LSB-first instances
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_piso_tx;

  logic       clk = 1'b0;
  logic       clr_n;
  logic [3:0] pi;
  logic       load;
  logic       ready_m, so_m, so_valid_m, done_m;
  logic       ready_l, so_l, so_valid_l, done_l;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       bm;
    logic       bl;
    logic       last;
    logic [3:0] word;
  } exp_t;

  exp_t       q[$];
  logic [3:0] sipo_po;
  logic [3:0] sipo_exp;
  bit         sipo_pend;

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
    .clk      (clk),
    .clr_n    (clr_n),
    .pi       (pi),
    .load     (load),
    .ready    (ready_m),
    .so       (so_m),
    .so_valid (so_valid_m),
    .done     (done_m)
  );

  piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
    .clk      (clk),
    .clr_n    (clr_n),
    .pi       (pi),
    .load     (load),
    .ready    (ready_l),
    .so       (so_l),
    .so_valid (so_valid_l),
    .done     (done_l)
  );

  // Receiving deserializer on the same clock, MSB-first.
  always @(posedge clk or negedge clr_n) begin
    if (!clr_n)          sipo_po <= 4'b0;
    else if (so_valid_m) sipo_po <= {sipo_po[2:0], so_m};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_cycle();
    exp_t e;
    if (q.size() > 0) begin
      e = q[0];
      chk("so_m", so_m, e.bm);
      chk("so_l", so_l, e.bl);
      chk("valid_m", so_valid_m, 1'b1);
      chk("valid_l", so_valid_l, 1'b1);
      chk("done_m", done_m, e.last);
      chk("done_l", done_l, e.last);
    end else begin
      chk("idle_so_m", so_m, 1'b0);
      chk("idle_so_l", so_l, 1'b0);
      chk("idle_valid_m", so_valid_m, 1'b0);
      chk("idle_valid_l", so_valid_l, 1'b0);
      chk("idle_done_m", done_m, 1'b0);
      chk("idle_done_l", done_l, 1'b0);
    end
    chk("ready_m", ready_m, q.size() <= 1);
    chk("ready_l", ready_l, q.size() <= 1);
    if (sipo_pend) begin
      chk("sipo_po", sipo_po, sipo_exp);
      sipo_pend = 1'b0;
    end
  endtask

  // One clock: drive at the falling edge, model the accept, check at the next falling edge.
  task automatic step(input logic ld, input logic [3:0] w);
    bit   acc;
    exp_t e;
    load = ld;
    pi   = w;
    acc  = ld && (q.size() <= 1);
    @(posedge clk);
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.last) begin
        sipo_pend = 1'b1;
        sipo_exp  = e.word;
      end
    end
    if (acc) begin
      for (int i = 0; i < 4; i++) begin
        e.bm   = w[3-i];
        e.bl   = w[i];
        e.last = (i == 3);
        e.word = w;
        q.push_back(e);
      end
    end
    @(negedge clk);
    check_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'b0000);
  endtask

  task automatic reset_now();
    load  = 1'b0;
    clr_n = 1'b0;
    #1;
    chk("rst_so_m", so_m, 1'b0);
    chk("rst_valid_m", so_valid_m, 1'b0);
    chk("rst_done_m", done_m, 1'b0);
    chk("rst_ready_m", ready_m, 1'b1);
    chk("rst_so_l", so_l, 1'b0);
    chk("rst_valid_l", so_valid_l, 1'b0);
    chk("rst_ready_l", ready_l, 1'b1);
    q.delete();
    sipo_pend = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  initial begin
    clr_n = 1'b0;
    load  = 1'b0;
    pi    = 4'b0;
    sipo_pend = 1'b0;
    repeat (2) @(negedge clk);
    reset_now();
    check_cycle();

    // Single word, both bit orders, then back to idle.
    step(1'b1, 4'b1011);
    idle(5);

    // Back-to-back: load held high, second word taken in the last-bit cycle.
    step(1'b1, 4'b1011);
    for (int i = 0; i < 4; i++) step(1'b1, 4'b0110);
    idle(5);

    // Load while busy is ignored.
    step(1'b1, 4'b1100);
    step(1'b1, 4'b0011);
    step(1'b1, 4'b0011);
    idle(5);

    // Reset mid-frame after two bits, then a clean word.
    step(1'b1, 4'b1111);
    step(1'b0, 4'b0000);
    reset_now();
    check_cycle();
    step(1'b1, 4'b0101);
    idle(5);

    // Random traffic.
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom));
    end
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_piso_tx

`default_nettype wire
